// File: rtl/fetch_queue_unit.sv
// Instruction-fetch queue: requests instructions from a single-outstanding memory
// port and buffers {pc, ir} pairs in a DEPTH-entry FIFO in front of the ID stage.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk_i,
    input  logic            n_rst_i,
    input  logic            ID_stall_i,
    input  logic            MEM_do_branch_i,
    input  logic [XLEN-1:0] MEM_pc_branched_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            IFID_valid_o,
    output logic [XLEN-1:0] IFID_pc_o,
    output logic [XLEN-1:0] IFID_ir_o
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W+1:0]  DEPTH_W = (PTR_W + 2)'(DEPTH);
    localparam logic [XLEN-1:0]   STEP_W  = XLEN'(PC_STEP);
    localparam logic [PTR_W:0]    CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pend_q, pend_d;
    logic             drop_q, drop_d;

    logic [XLEN-1:0]  fifo_pc_mem [DEPTH];
    logic [XLEN-1:0]  fifo_ir_mem [DEPTH];

    logic             grant;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic [PTR_W+1:0] occupancy;

    // The pending request counts as occupied so its response always has a slot.
    always_comb begin
        occupancy  = {1'b0, count_q} + {{(PTR_W + 1){1'b0}}, pend_q};
        imem_req_o = (occupancy < DEPTH_W) && (!pend_q || imem_rvalid_i);
        grant      = imem_req_o && imem_gnt_i;
        head_valid = (count_q != '0);
        push       = imem_rvalid_i && pend_q && !drop_q && !MEM_do_branch_i;
        pop        = head_valid && !ID_stall_i && !MEM_do_branch_i;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pend_d     = pend_q;
        drop_d     = drop_q;

        if (grant) begin
            pend_d    = 1'b1;
            pend_pc_d = fetch_pc_q;
        end else if (imem_rvalid_i) begin
            pend_d = 1'b0;
        end

        if (MEM_do_branch_i) begin
            // A grant in this cycle still fetched the old address; mark it for disposal.
            fetch_pc_d = MEM_pc_branched_i;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_d     = pend_d;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + STEP_W;
            end
            if (grant || imem_rvalid_i) begin
                drop_d = 1'b0;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc_mem[wr_ptr_q] <= pend_pc_q;
            fifo_ir_mem[wr_ptr_q] <= imem_rdata_i;
        end
    end

    // Storage is not reset, so the head is masked to zero whenever the queue is empty.
    assign imem_addr_o  = fetch_pc_q;
    assign IFID_valid_o = head_valid;
    assign IFID_pc_o    = head_valid ? fifo_pc_mem[rd_ptr_q] : '0;
    assign IFID_ir_o    = head_valid ? fifo_ir_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a variable-latency memory model feeds the
// DUT and a scoreboard queue holds the pc sequence the ID side must receive.
module tb_fetch_queue_unit;

    logic        clk_i;
    logic        n_rst_i;
    logic        ID_stall_i;
    logic        MEM_do_branch_i;
    logic [31:0] MEM_pc_branched_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        IFID_valid_o;
    logic [31:0] IFID_pc_o;
    logic [31:0] IFID_ir_o;

    fetch_queue_unit dut (
        .clk_i            (clk_i),
        .n_rst_i          (n_rst_i),
        .ID_stall_i       (ID_stall_i),
        .MEM_do_branch_i  (MEM_do_branch_i),
        .MEM_pc_branched_i(MEM_pc_branched_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .IFID_valid_o     (IFID_valid_o),
        .IFID_pc_o        (IFID_pc_o),
        .IFID_ir_o        (IFID_ir_o)
    );

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [31:0] expq [$];

    int          rlat     = 1;
    int          gdelay   = 0;
    logic        m_busy   = 1'b0;
    int          m_lat    = 0;
    logic [31:0] m_addr   = '0;
    int          wait_ctr = 0;
    logic        hold_v   = 1'b0;
    logic [31:0] hold_addr = '0;
    logic        hs_gnt, hs_rv;
    logic [31:0] hs_addr;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: response after rlat cycles, grant after gdelay waiting cycles, one outstanding.
    initial begin
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            if (m_busy && m_lat == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = m_addr + 32'h1000;
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'hDEAD_BEEF;
            end
            #1;
            if (n_rst_i && imem_req_o) begin
                if (hold_v) check("addr_stable", imem_addr_o, hold_addr);
                if (wait_ctr >= gdelay && (!m_busy || imem_rvalid_i)) begin
                    imem_gnt_i = 1'b1;
                    hold_v     = 1'b0;
                    wait_ctr   = 0;
                end else begin
                    imem_gnt_i = 1'b0;
                    hold_v     = 1'b1;
                    hold_addr  = imem_addr_o;
                    wait_ctr++;
                end
            end else begin
                imem_gnt_i = 1'b0;
                hold_v     = 1'b0;
                wait_ctr   = 0;
            end
            hs_gnt  = imem_gnt_i && imem_req_o;
            hs_rv   = imem_rvalid_i;
            hs_addr = imem_addr_o;
            @(posedge clk_i);
            if (hs_rv) m_busy = 1'b0;
            if (hs_gnt && n_rst_i) begin
                m_busy = 1'b1;
                m_addr = hs_addr;
                m_lat  = rlat - 1;
            end else if (m_busy && m_lat > 0) begin
                m_lat--;
            end
        end
    end

    // ID side: every accepted head entry is compared against the scoreboard.
    always @(negedge clk_i) begin
        if (n_rst_i) begin
            if (IFID_valid_o && !ID_stall_i && !MEM_do_branch_i) begin
                checks++;
                assert (expq.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_pop observed pc=%h expected no entry", IFID_pc_o);
                end
                if (expq.size() != 0) begin
                    logic [31:0] e;
                    e = expq.pop_front();
                    check("pop_pc", IFID_pc_o, e);
                    check("pop_ir", IFID_ir_o, e + 32'h1000);
                end
                pops++;
            end else if (!IFID_valid_o) begin
                check("idle_pc_zero", IFID_pc_o, 32'h0);
                check("idle_ir_zero", IFID_ir_o, 32'h0);
            end
        end
    end

    task automatic expect_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) expq.push_back(base + 32'(i * 4));
    endtask

    task automatic consume(input int k, output int cyc);
        int target;
        target = pops + k;
        cyc = 0;
        ID_stall_i = 1'b0;
        while (pops < target && cyc < 300) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        ID_stall_i = 1'b1;
        check("consume_count", pops, target);
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!m_busy && n < 40) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("mem_busy_reached", m_busy, 1'b1);
    endtask

    task automatic branch_to(input logic [31:0] tgt);
        MEM_pc_branched_i = tgt;
        MEM_do_branch_i   = 1'b1;
        @(posedge clk_i);
        #1;
        MEM_do_branch_i   = 1'b0;
        check("valid_after_branch", IFID_valid_o, 1'b0);
    endtask

    initial begin
        int cyc;
        int n;
        n_rst_i           = 1'b0;
        ID_stall_i        = 1'b1;
        MEM_do_branch_i   = 1'b0;
        MEM_pc_branched_i = '0;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", IFID_valid_o, 1'b0);
        check("rst_pc", IFID_pc_o, 32'h0);
        check("rst_ir", IFID_ir_o, 32'h0);
        n_rst_i = 1'b1;
        #1;
        check("req_after_rst", imem_req_o, 1'b1);
        check("addr_after_rst", imem_addr_o, 32'h0);

        // free run, one instruction per cycle
        expect_seq(32'h0, 16);
        consume(16, cyc);
        check("throughput_cycles_le_18", (cyc <= 18), 1'b1);

        // long stall fills the queue and withholds requests
        repeat (10) @(posedge clk_i);
        #1;
        check("stall_req_low", imem_req_o, 1'b0);
        check("stall_valid", IFID_valid_o, 1'b1);
        check("stall_head_pc", IFID_pc_o, 32'h40);
        expect_seq(32'h40, 12);
        consume(12, cyc);

        // grant delayed three cycles per request
        gdelay = 3;
        expect_seq(32'h70, 6);
        consume(6, cyc);
        gdelay = 0;

        // branch while a slow request is outstanding
        rlat = 5;
        expect_seq(32'h88, 2);
        consume(2, cyc);
        wait_busy();
        branch_to(32'h100);
        rlat = 1;
        expect_seq(32'h100, 4);
        consume(4, cyc);

        // branch in the same cycle as a grant
        expect_seq(32'h110, 1);
        consume(1, cyc);
        n = 0;
        do begin
            @(negedge clk_i);
            #2;
            n++;
        end while (!(imem_gnt_i && imem_req_o) && n < 40);
        check("grant_seen", imem_gnt_i && imem_req_o, 1'b1);
        branch_to(32'h40);
        expect_seq(32'h40, 4);
        consume(4, cyc);

        // branch in the same cycle as an rvalid; target fetched with minimum latency
        repeat (6) @(posedge clk_i);
        #1;
        rlat = 3;
        expect_seq(32'h50, 1);
        consume(1, cyc);
        n = 0;
        do begin
            @(negedge clk_i);
            #2;
            n++;
        end while (!imem_rvalid_i && n < 40);
        check("rvalid_seen", imem_rvalid_i, 1'b1);
        rlat = 1;
        branch_to(32'h200);
        @(posedge clk_i);
        #1;
        check("branch_t1_valid", IFID_valid_o, 1'b0);
        @(posedge clk_i);
        #1;
        check("branch_t2_valid", IFID_valid_o, 1'b1);
        check("branch_t2_pc", IFID_pc_o, 32'h200);
        expect_seq(32'h200, 2);
        consume(2, cyc);

        // asynchronous reset with a response still in flight
        repeat (6) @(posedge clk_i);
        #1;
        rlat = 4;
        expect_seq(32'h208, 1);
        consume(1, cyc);
        wait_busy();
        check("pre_rst_valid", IFID_valid_o, 1'b1);
        #2;
        n_rst_i = 1'b0;
        #1;
        check("async_rst_valid", IFID_valid_o, 1'b0);
        check("async_rst_pc", IFID_pc_o, 32'h0);
        check("async_rst_ir", IFID_ir_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rlat = 1;
        n_rst_i = 1'b1;
        #1;
        check("restart_addr", imem_addr_o, 32'h0);
        expect_seq(32'h0, 4);
        consume(4, cyc);

        check("scoreboard_drained", expq.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
